stage3_kernel_sched: RTL and testbench

- Sequencer for the stage-3 multiply-accumulate kernel (POOL_CI-wide dot-product, 2-cycle latency).
- For each of CO output channels, streams N_POS pooled feature vectors and the matching weight vectors into the kernel.
- Accumulates the N_POS kernel sums into one result per output channel and emits it on a valid/ready port.
- Sits between the pooling-output buffer / weight ROM and the stage-3 output collector.

---
 rtl/stage3_kernel_sched_pkg.sv | 27 ++
 rtl/stage3_sched_acc.sv | 43 ++++
 rtl/stage3_kernel_sched.sv | 105 ++++++++++
 tb/tb_stage3_kernel_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage3_kernel_sched_pkg.sv
// stage3_kernel_sched_pkg: shared stage-3 sizing defaults, derived widths and FSM state encodings.
//   POOL_CI/OF_BW/W_BW/N_POS/CO/KER_BW/ACC_BW : kernel and frame geometry
//   PW/CW/WAW/CNT_BW                           : address, channel and counter widths (min 1 bit)
//   ST_IDLE..ST_OUT / state_t                  : scheduler FSM encodings
package stage3_kernel_sched_pkg;
    localparam int POOL_CI = 3;
    localparam int OF_BW   = 14;
    localparam int W_BW    = 8;
    localparam int N_POS   = 16;
    localparam int CO      = 3;
    localparam int KER_BW  = OF_BW + W_BW + 2;
    localparam int ACC_BW  = KER_BW + $clog2(N_POS);
    localparam int PW      = (N_POS > 1) ? $clog2(N_POS) : 1;
    localparam int CW      = (CO > 1) ? $clog2(CO) : 1;
    localparam int WAW     = (CO * N_POS > 1) ? $clog2(CO * N_POS) : 1;
    localparam int CNT_BW  = $clog2(N_POS + 1);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        DRAIN = ST_DRAIN,
        OUT   = ST_OUT
    } state_t;
endpackage

// File: rtl/stage3_sched_acc.sv
// stage3_sched_acc: per-channel accumulator and received-result counter with optional ReLU output.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_clr        : clear accumulator and counter (priority over i_en)
//   i_en         : add i_kernel (sign-extended) and count one result
//   i_kernel     : signed kernel sum
//   o_full       : counter reaches N_POS including the result being added this cycle
//   o_result     : accumulated value; clamped at 0 when STAGE3_SCHED_RELU_EN is defined
module stage3_sched_acc
    import stage3_kernel_sched_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [KER_BW-1:0] i_kernel,
    output logic                     o_full,
    output logic signed [ACC_BW-1:0] o_result
);
    logic signed [ACC_BW-1:0] acc;
    logic [CNT_BW-1:0]        rcv_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            rcv_cnt <= '0;
        end else if (i_clr) begin
            acc     <= '0;
            rcv_cnt <= '0;
        end else if (i_en) begin
            acc     <= acc + ACC_BW'(i_kernel);
            rcv_cnt <= rcv_cnt + 1'b1;
        end
    end

    // Looking one result ahead lets the FSM leave DRAIN on the same edge the last sum lands.
    assign o_full = (rcv_cnt == CNT_BW'(N_POS)) || (i_en && rcv_cnt == CNT_BW'(N_POS - 1));

`ifdef STAGE3_SCHED_RELU_EN
    assign o_result = acc[ACC_BW-1] ? '0 : acc;
`else
    assign o_result = acc;
`endif
endmodule

// File: rtl/stage3_kernel_sched.sv
// stage3_kernel_sched: sequences pooled vectors and weights into the stage-3 MAC kernel and
// accumulates N_POS kernel sums per output channel. Optional macro: STAGE3_SCHED_RELU_EN.
//   clk, reset_n                      : clock, asynchronous active-low reset
//   i_start / o_busy / o_done         : frame start (idle only), busy flag, end-of-frame pulse
//   o_feat_addr / i_feat_data         : pooled-buffer read port (1-cycle latency)
//   o_w_addr / i_w_data               : weight ROM read port (1-cycle latency)
//   o_pooling_valid/o_pooling/o_weight: kernel input strobe and operands
//   i_kernel_valid / i_kernel         : kernel result
//   o_result_valid/o_result_ch/o_result/i_result_ready : per-channel result handshake
module stage3_kernel_sched
    import stage3_kernel_sched_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_start,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [PW-1:0]               o_feat_addr,
    input  logic [POOL_CI*OF_BW-1:0]    i_feat_data,
    output logic [WAW-1:0]              o_w_addr,
    input  logic [POOL_CI*W_BW-1:0]     i_w_data,
    output logic                        o_pooling_valid,
    output logic [POOL_CI*OF_BW-1:0]    o_pooling,
    output logic [POOL_CI*W_BW-1:0]     o_weight,
    input  logic                        i_kernel_valid,
    input  logic signed [KER_BW-1:0]    i_kernel,
    output logic                        o_result_valid,
    output logic [CW-1:0]               o_result_ch,
    output logic signed [ACC_BW-1:0]    o_result,
    input  logic                        i_result_ready
);
    state_t                   state, state_d;
    logic [PW-1:0]            pos, feat_q;
    logic [WAW-1:0]           w_addr, w_q;
    logic [CW-1:0]            co;
    logic                     pv_q, done_q, hs, last_ch, last_pos, go, acc_en, acc_clr, acc_full;
    logic signed [ACC_BW-1:0] acc_out;

    assign go       = state == IDLE && i_start;
    assign hs       = state == OUT && i_result_ready;
    assign last_ch  = co == CW'(CO - 1);
    assign last_pos = pos == PW'(N_POS - 1);
    assign w_addr   = WAW'(co) * WAW'(N_POS) + WAW'(pos);
    // Results arriving outside a channel's issue/drain window are stale and must not accumulate.
    assign acc_en   = i_kernel_valid && (state == ISSUE || state == DRAIN);
    assign acc_clr  = go || hs;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = i_start ? ISSUE : IDLE;
            ISSUE:   state_d = last_pos ? DRAIN : ISSUE;
            DRAIN:   state_d = acc_full ? OUT : DRAIN;
            OUT:     state_d = i_result_ready ? (last_ch ? IDLE : ISSUE) : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pos    <= '0;
            co     <= '0;
            feat_q <= '0;
            w_q    <= '0;
            pv_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            pv_q   <= state == ISSUE;
            done_q <= hs && last_ch;
            if (state == ISSUE) begin
                pos    <= last_pos ? '0 : pos + 1'b1;
                feat_q <= pos;
                w_q    <= w_addr;
            end
            if (go)
                co <= '0;
            else if (hs)
                co <= last_ch ? '0 : co + 1'b1;
        end
    end

    stage3_sched_acc u_acc (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (acc_clr),
        .i_en     (acc_en),
        .i_kernel (i_kernel),
        .o_full   (acc_full),
        .o_result (acc_out)
    );

    // Addresses are live during ISSUE and otherwise hold the last issued value.
    assign o_feat_addr     = state == ISSUE ? pos : feat_q;
    assign o_w_addr        = state == ISSUE ? w_addr : w_q;
    assign o_busy          = state != IDLE;
    assign o_done          = done_q;
    assign o_pooling_valid = pv_q;
    assign o_pooling       = pv_q ? i_feat_data : '0;
    assign o_weight        = pv_q ? i_w_data : '0;
    assign o_result_valid  = state == OUT;
    assign o_result_ch     = state == OUT ? co : '0;
    assign o_result        = state == OUT ? acc_out : '0;
endmodule

// File: tb/tb_stage3_kernel_sched.sv
// tb_stage3_kernel_sched: directed bench with memory and 2-cycle kernel models around stage3_kernel_sched.
module tb_stage3_kernel_sched;
    import stage3_kernel_sched_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     i_start = 1'b0;
    logic                     o_busy, o_done;
    logic [PW-1:0]            o_feat_addr;
    logic [POOL_CI*OF_BW-1:0] i_feat_data;
    logic [WAW-1:0]           o_w_addr;
    logic [POOL_CI*W_BW-1:0]  i_w_data;
    logic                     o_pooling_valid;
    logic [POOL_CI*OF_BW-1:0] o_pooling;
    logic [POOL_CI*W_BW-1:0]  o_weight;
    logic                     i_kernel_valid;
    logic signed [KER_BW-1:0] i_kernel;
    logic                     o_result_valid;
    logic [CW-1:0]            o_result_ch;
    logic signed [ACC_BW-1:0] o_result;
    logic                     i_result_ready = 1'b1;

    stage3_kernel_sched dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_start         (i_start),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_feat_addr     (o_feat_addr),
        .i_feat_data     (i_feat_data),
        .o_w_addr        (o_w_addr),
        .i_w_data        (i_w_data),
        .o_pooling_valid (o_pooling_valid),
        .o_pooling       (o_pooling),
        .o_weight        (o_weight),
        .i_kernel_valid  (i_kernel_valid),
        .i_kernel        (i_kernel),
        .o_result_valid  (o_result_valid),
        .o_result_ch     (o_result_ch),
        .o_result        (o_result),
        .i_result_ready  (i_result_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int feat_val = 1, w_val = 1;
    bit addr_mode = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pooled buffer and weight ROM: one-cycle registered reads.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < POOL_CI; i++) begin
            i_feat_data[i*OF_BW +: OF_BW] <= OF_BW'(addr_mode ? int'(o_feat_addr) : feat_val);
            i_w_data[i*W_BW +: W_BW]      <= W_BW'(addr_mode ? int'(o_w_addr) : w_val);
        end
    end

    function automatic longint dot(input logic [POOL_CI*OF_BW-1:0] p, input logic [POOL_CI*W_BW-1:0] w);
        longint s = 0;
        for (int i = 0; i < POOL_CI; i++)
            s += longint'($signed(p[i*OF_BW +: OF_BW])) * longint'($signed(w[i*W_BW +: W_BW]));
        return s;
    endfunction

    // Ideal two-cycle kernel.
    logic                     v1 = 1'b0;
    logic signed [KER_BW-1:0] s1 = '0;
    initial begin
        i_kernel_valid = 1'b0;
        i_kernel = '0;
    end
    always @(posedge clk) begin
        v1             <= o_pooling_valid;
        s1             <= KER_BW'(dot(o_pooling, o_weight));
        i_kernel_valid <= v1;
        i_kernel       <= s1;
    end

    longint res_q[$];
    int     ch_q[$], runs[$], pf_q[$], pw_q[$];
    int     run = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0, first_cyc = 0, st_cyc = 0;
    bit     seen_valid = 1'b0;

    always @(negedge clk) begin
        if (o_result_valid && !seen_valid) begin
            seen_valid = 1'b1;
            first_cyc  = cyc;
        end
        if (o_result_valid && i_result_ready) begin
            res_q.push_back(longint'(o_result));
            ch_q.push_back(int'(o_result_ch));
            acc_cyc = cyc;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (o_pooling_valid) begin
            run++;
            pf_q.push_back(int'(o_pooling[OF_BW-1:0]));
            pw_q.push_back(int'(o_weight[W_BW-1:0]));
        end else if (run > 0) begin
            runs.push_back(run);
            run = 0;
        end
    end

    task automatic clear_log();
        res_q.delete();
        ch_q.delete();
        runs.delete();
        pf_q.delete();
        pw_q.delete();
        seen_valid = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk);
        #1 i_start = 1'b1;
        st_cyc = cyc;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 600 && done_cnt == d0; i++) @(negedge clk);
        check({tag, "_done"}, done_cnt - d0, 1);
    endtask

    task automatic check_results(input string tag, input longint e0, input longint e1, input longint e2);
        longint e[3];
        e = '{e0, e1, e2};
        check({tag, "_nres"}, res_q.size(), 3);
        for (int i = 0; i < 3 && i < res_q.size(); i++) begin
            check($sformatf("%s_res%0d", tag, i), res_q[i], e[i]);
            check($sformatf("%s_ch%0d", tag, i), ch_q[i], i);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_rvalid"}, o_result_valid, 0);
        check({tag, "_result"}, o_result, 0);
        check({tag, "_pvalid"}, o_pooling_valid, 0);
        check({tag, "_faddr"}, o_feat_addr, 0);
        check({tag, "_waddr"}, o_w_addr, 0);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("post_reset");

        // Basic frame: all ones -> 3 lanes * 16 positions = 48 per channel.
        clear_log();
        d0 = done_cnt;
        start_frame();
        check("basic_busy", o_busy, 1);
        wait_done("basic", d0);
        check_results("basic", 48, 48, 48);
        check("basic_done_lat", done_cyc - acc_cyc, 1);
        check("basic_issue_to_out", first_cyc - st_cyc, 20);
        check("basic_nruns", runs.size(), 3);
        foreach (runs[i]) check($sformatf("basic_run%0d", i), runs[i], 16);
        @(negedge clk);
        check("basic_idle_busy", o_busy, 0);

        // Addressing: feature lane = feat addr, weight lane = weight addr.
        // Channel c: 3 * sum_p p*(16c+p) = 5760c + 3720.
        clear_log();
        addr_mode = 1'b1;
        d0 = done_cnt;
        start_frame();
        wait_done("addr", d0);
        check_results("addr", 3720, 9480, 15240);
        check("addr_nstrobes", pw_q.size(), 48);
        for (int n = 0; n < 48 && n < pw_q.size(); n++) begin
            check($sformatf("addr_w%0d", n), pw_q[n], n);
            check($sformatf("addr_f%0d", n), pf_q[n], n % 16);
        end
        addr_mode = 1'b0;

        // Back-pressure on channel 1.
        clear_log();
        d0 = done_cnt;
        start_frame();
        for (int i = 0; i < 200 && res_q.size() < 1; i++) @(negedge clk);
        @(posedge clk);
        #1 i_result_ready = 1'b0;
        for (int i = 0; i < 200 && !o_result_valid; i++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", o_result_valid, 1);
            check("bp_result", o_result, 48);
            check("bp_ch", o_result_ch, 1);
            check("bp_no_issue", o_pooling_valid, 0);
        end
        @(posedge clk);
        #1 i_result_ready = 1'b1;
        wait_done("bp", d0);
        check_results("bp", 48, 48, 48);

        // Signed operands: 3 * (-2*3) * 16 = -288, clamped by ReLU.
        clear_log();
        feat_val = -2;
        w_val = 3;
        d0 = done_cnt;
        start_frame();
        wait_done("signed", d0);
`ifdef STAGE3_SCHED_RELU_EN
        check_results("signed", 0, 0, 0);
`else
        check_results("signed", -288, -288, -288);
`endif
        feat_val = 1;
        w_val = 1;

        // Reset during channel 1 DRAIN, then a clean frame.
        clear_log();
        d0 = done_cnt;
        start_frame();
        for (int i = 0; i < 200 && res_q.size() < 1; i++) @(negedge clk);
        @(posedge clk);
        repeat (17) @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check_idle_outputs("rst_mid");
        check("rst_mid_ch", o_result_ch, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_nres", res_q.size(), 1);
        clear_log();
        d0 = done_cnt;
        start_frame();
        wait_done("rst_restart", d0);
        check_results("rst_restart", 48, 48, 48);

        // Start pulse while busy is ignored.
        clear_log();
        d0 = done_cnt;
        start_frame();
        repeat (3) @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        wait_done("busy_start", d0);
        repeat (40) @(negedge clk);
        check("busy_start_ndone", done_cnt - d0, 1);
        check_results("busy_start", 48, 48, 48);
        check("busy_start_idle", o_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
